// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 window generator for the Sobel datapath: buffers two previous
// rows of a raster pixel stream and emits one window per interior pixel.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [7:0]                 in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 row0_0,
  output logic [7:0]                 row0_1,
  output logic [7:0]                 row0_2,
  output logic [7:0]                 row1_0,
  output logic [7:0]                 row1_1,
  output logic [7:0]                 row1_2,
  output logic [7:0]                 row2_0,
  output logic [7:0]                 row2_1,
  output logic [7:0]                 row2_2,
  output logic                       win_valid,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y,
  output logic                       win_last,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  // Window columns held as packed triples; index 0 is the leftmost column.
  logic [2:0][7:0] w0_q, w0_d;
  logic [2:0][7:0] w1_q, w1_d;
  logic [2:0][7:0] w2_q, w2_d;

  logic            win_valid_q, win_valid_d;
  logic            win_last_q, win_last_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   win_x_q, win_x_d;
  logic [RW-1:0]   win_y_q, win_y_d;

  logic [7:0]      lb0_mem [IMG_W];
  logic [7:0]      lb1_mem [IMG_W];
  logic [7:0]      lb0_rd, lb1_rd;

  logic            xfer;
  logic            col_last, row_last;

  assign in_ready = (state_q == FILL) || (state_q == RUN);
  assign xfer     = in_valid && in_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign lb0_rd   = lb0_mem[col_q];
  assign lb1_rd   = lb1_mem[col_q];

  // NOTE: line-buffer RAM has no reset so it maps onto plain memory; every
  // entry is rewritten in the two fill rows before any window reads it.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb0_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= in_pixel;
    end
  end

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    w0_d         = w0_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    win_valid_d  = 1'b0;
    win_last_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;

    if (xfer) begin
      // Shift runs on every transfer so the first two columns of a line prime it.
      w0_d = {lb0_rd,   w0_q[2:1]};
      w1_d = {lb1_rd,   w1_q[2:1]};
      w2_d = {in_pixel, w2_q[2:1]};

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : RW'(row_q + RW'(1));
      end else begin
        col_d = CW'(col_q + CW'(1));
      end

      if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
        win_valid_d = 1'b1;
        win_x_d     = CW'(col_q - CW'(1));
        win_y_d     = RW'(row_q - RW'(1));
        win_last_d  = row_last && col_last;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL: begin
        if (xfer && col_last && (row_q == RW'(1))) state_d = RUN;
      end
      RUN: begin
        if (xfer && col_last && row_last) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // '=' above belongs solely to the combinational next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
    end
  end

  assign row0_0     = w0_q[0];
  assign row0_1     = w0_q[1];
  assign row0_2     = w0_q[2];
  assign row1_0     = w1_q[0];
  assign row1_1     = w1_q[1];
  assign row1_2     = w1_q[2];
  assign row2_0     = w2_q[0];
  assign row2_1     = w2_q[1];
  assign row2_2     = w2_q[2];
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: a 5x4 instance driven through several
// frames with a decoupled window monitor, plus a 3x3 minimum-size instance.
module tb_sobel_window_ctrl;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct packed {
    logic [8:0][7:0] pix;
    logic [7:0]      x;
    logic [7:0]      y;
    logic            last;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready;
  logic [7:0] in_pixel;
  logic [7:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
  logic       win_valid, win_last, frame_done, busy;
  logic [2:0] win_x;
  logic [1:0] win_y;

  logic       m_start, m_in_valid, m_in_ready;
  logic [7:0] m_in_pixel;
  logic [7:0] m00, m01, m02, m10, m11, m12, m20, m21, m22;
  logic       m_win_valid, m_win_last, m_frame_done, m_busy;
  logic [1:0] m_win_x, m_win_y;

  win_t sb_q[$];
  win_t first_w, last_w;
  int   n_checks = 0;
  int   n_err = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;
  int   m_win_cnt = 0;
  logic xfer_prev = 1'b0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pixel(in_pixel),
    .in_valid(in_valid), .in_ready(in_ready),
    .row0_0(r00), .row0_1(r01), .row0_2(r02),
    .row1_0(r10), .row1_1(r11), .row1_2(r12),
    .row2_0(r20), .row2_1(r21), .row2_2(r22),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .win_last(win_last), .frame_done(frame_done), .busy(busy)
  );

  sobel_window_ctrl #(.IMG_W(3), .IMG_H(3)) dut_min (
    .clk(clk), .rst_n(rst_n), .start(m_start), .in_pixel(m_in_pixel),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .row0_0(m00), .row0_1(m01), .row0_2(m02),
    .row1_0(m10), .row1_1(m11), .row1_2(m12),
    .row2_0(m20), .row2_1(m21), .row2_2(m22),
    .win_valid(m_win_valid), .win_x(m_win_x), .win_y(m_win_y),
    .win_last(m_win_last), .frame_done(m_frame_done), .busy(m_busy)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    logic [7:0] p;
    p = 8'(16 * r + c);
    return (mode != 0) ? 8'hFF - p : p;
  endfunction

  always @(posedge clk) xfer_prev <= in_valid && in_ready;

  // Monitor: pops the scoreboard whenever the DUT presents a window.
  always @(negedge clk) begin
    win_t a, e;
    if (rst_n && win_valid) begin
      a.pix  = {r22, r21, r20, r12, r11, r10, r02, r01, r00};
      a.x    = 8'(win_x);
      a.y    = 8'(win_y);
      a.last = win_last;
      check("win_after_xfer", 96'(xfer_prev), 96'(1));
      check("sb_nonempty", 96'(sb_q.size() != 0), 96'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("window", 96'(a), 96'(e));
      end
      if (win_cnt == 0) first_w = a;
      last_w = a;
      win_cnt++;
    end
    if (rst_n && frame_done) begin
      done_cnt++;
      check("done_with_valid", 96'(win_valid), 96'(1));
      check("done_with_last", 96'(win_last), 96'(1));
      check("done_after_xfer", 96'(xfer_prev), 96'(1));
    end
  end

  always @(negedge clk) if (rst_n && m_win_valid) m_win_cnt++;

  task automatic start_frame();
    @(negedge clk);
    check("idle_busy", 96'(busy), 96'(0));
    check("idle_ready", 96'(in_ready), 96'(0));
    win_cnt  = 0;
    done_cnt = 0;
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 96'(busy), 96'(1));
    check("start_ready", 96'(in_ready), 96'(1));
  endtask

  task automatic drive_frame(input int mode, input bit stall, input bit inject, input int max_x);
    int   r = 0, c = 0, n = 0, cyc = 0;
    bit   v;
    win_t e;
    while (n < W * H && n < max_x && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      v        = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_pixel = pix(mode, r, c);
      start    = inject && (r == 2) && (c == 3);
      if (v && in_ready) begin
        if (r >= 2 && c >= 2) begin
          for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
              e.pix[k*3+j] = pix(mode, r - 2 + k, c - 2 + j);
          e.x    = 8'(c - 1);
          e.y    = 8'(r - 1);
          e.last = (r == H - 1) && (c == W - 1);
          sb_q.push_back(e);
        end
        n++;
        if (c == W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
    end
    check("drive_progress", 96'((n >= W * H) || (n >= max_x)), 96'(1));
  endtask

  task automatic wait_done();
    int cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      cyc++;
    end while (!frame_done && cyc < 20);
    #1;
    check("frame_done_seen", 96'(frame_done), 96'(1));
    check("win_count", 96'(win_cnt), 96'(6));
    check("done_count", 96'(done_cnt), 96'(1));
    check("sb_empty", 96'(sb_q.size()), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [71:0] m_exp;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'h00;
    m_start = 1'b0; m_in_valid = 1'b0; m_in_pixel = 8'h00;

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_pixel = 8'($urandom);
    end
    #1;
    check("rst_in_ready", 96'(in_ready), 96'(0));
    check("rst_win_valid", 96'(win_valid), 96'(0));
    check("rst_win_last", 96'(win_last), 96'(0));
    check("rst_frame_done", 96'(frame_done), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_window", 96'({r00, r01, r02, r10, r11, r12, r20, r21, r22}), 96'(0));
    check("rst_win_xy", 96'({win_x, win_y}), 96'(0));

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;

    // in_valid while idle must not be accepted.
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_gate_ready", 96'(in_ready), 96'(0));
    check("idle_gate_busy", 96'(busy), 96'(0));
    check("idle_gate_valid", 96'(win_valid), 96'(0));
    in_valid = 1'b0;

    // Frame 1: continuous, with a start pulse injected mid-RUN.
    start_frame();
    drive_frame(0, 1'b0, 1'b1, 1000);
    wait_done();
    check("f1_first_r00", 96'(first_w.pix[0]), 96'(8'h00));
    check("f1_first_r11", 96'(first_w.pix[4]), 96'(8'h11));
    check("f1_first_r22", 96'(first_w.pix[8]), 96'(8'h22));
    check("f1_first_xy", 96'({first_w.x, first_w.y}), 96'({8'd1, 8'd1}));
    check("f1_last_r00", 96'(last_w.pix[0]), 96'(8'h12));
    check("f1_last_r22", 96'(last_w.pix[8]), 96'(8'h34));
    check("f1_last_xy", 96'({last_w.x, last_w.y}), 96'({8'd3, 8'd2}));
    check("f1_last_flag", 96'(last_w.last), 96'(1));

    // Frame 2: random stalls, started back-to-back.
    start_frame();
    drive_frame(0, 1'b1, 1'b0, 1000);
    wait_done();
    check("f2_last_r22", 96'(last_w.pix[8]), 96'(8'h34));

    // Frame 3: inverted pixels, back-to-back.
    start_frame();
    drive_frame(1, 1'b0, 1'b0, 1000);
    wait_done();
    check("f3_first_r00", 96'(first_w.pix[0]), 96'(8'hFF));
    check("f3_first_r11", 96'(first_w.pix[4]), 96'(8'hEE));
    check("f3_last_r22", 96'(last_w.pix[8]), 96'(8'hCB));

    // Asynchronous reset just after the first window of a frame.
    start_frame();
    drive_frame(0, 1'b0, 1'b0, 13);
    @(negedge clk);
    #1;
    check("pre_rst_valid", 96'(win_valid), 96'(1));
    check("pre_rst_busy", 96'(busy), 96'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 96'(win_valid), 96'(0));
    check("async_rst_busy", 96'(busy), 96'(0));
    check("async_rst_ready", 96'(in_ready), 96'(0));
    check("async_rst_sb", 96'(sb_q.size()), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 96'(in_ready), 96'(0));
    check("post_rst_busy", 96'(busy), 96'(0));
    in_valid = 1'b0;

    // Minimum 3x3 frame on the second instance.
    m_win_cnt = 0;
    @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    check("min_ready", 96'(m_in_ready), 96'(1));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        m_in_valid = 1'b1;
        m_in_pixel = pix(0, r, c);
        @(negedge clk);
      end
    m_in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        m_exp[(k*3+j)*8 +: 8] = pix(0, k, j);
    check("min_valid", 96'(m_win_valid), 96'(1));
    check("min_xy", 96'({m_win_x, m_win_y}), 96'({2'd1, 2'd1}));
    check("min_last", 96'(m_win_last), 96'(1));
    check("min_done", 96'(m_frame_done), 96'(1));
    check("min_window", 96'({m22, m21, m20, m12, m11, m10, m02, m01, m00}), 96'(m_exp));
    @(negedge clk);
    #1;
    check("min_win_count", 96'(m_win_cnt), 96'(1));
    check("min_busy_clear", 96'(m_busy), 96'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
